// File: rtl/axis_loop_fifo_proc.sv
// ---------------------------------------------------------------------------
// axis_loop_fifo_proc
//
// AXI-Stream loopback processor used as a bring-up / throughput target between
// the host link adapters. Inbound beats are transformed on write and buffered
// in a DEPTH-entry FIFO. They are then returned on the outbound stream in
// arrival order.
//
// The inbound ready depends only on FIFO fullness, so host back-pressure on the
// outbound side never stalls the input through a combinational path.
//
// Parameters
//   PROC_WIDTH_BYTES : stream width in bytes (data width = 8*PROC_WIDTH_BYTES)
//   DEPTH            : FIFO entries, power of two, >= 2
//   MODE             : 0 pass-through, 1 bitwise invert, 2 byte-order reverse
//   CNT_WIDTH        : width of the outbound beat counter
//
// Ports
//   clk           : clock, everything on the rising edge
//   arstn         : synchronous active-low reset, also gates both handshakes
//   s_axis_tdata  : inbound data
//   s_axis_tvalid : inbound valid
//   s_axis_tready : inbound ready (FIFO not full)
//   m_axis_tdata  : outbound data (head of FIFO, show-ahead)
//   m_axis_tvalid : outbound valid (FIFO not empty)
//   m_axis_tready : outbound ready
//   occupancy     : number of entries currently held
//   beat_count    : outbound beats accepted since reset, wraps
// ---------------------------------------------------------------------------
module axis_loop_fifo_proc #(
    parameter int PROC_WIDTH_BYTES = 1,
    parameter int DEPTH            = 4,
    parameter int MODE             = 0,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                         clk,
    input  logic                         arstn,
    input  logic [8*PROC_WIDTH_BYTES-1:0] s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic [8*PROC_WIDTH_BYTES-1:0] m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNT_WIDTH-1:0]         beat_count
);

    localparam int DATA_W = 8 * PROC_WIDTH_BYTES;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W  = $clog2(DEPTH + 1);

    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_EMPTY = '0;

    // Reject configurations the pointer arithmetic and transform cannot handle.
    // Pointers rely on natural binary wrap, so DEPTH must be a power of two.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_badDepth
            $error("axis_loop_fifo_proc: DEPTH must be a power of 2 and >= 2");
        end
        if (MODE < 0 || MODE > 2) begin : g_badMode
            $error("axis_loop_fifo_proc: MODE must be 0, 1 or 2");
        end
        if (PROC_WIDTH_BYTES < 1) begin : g_badWidth
            $error("axis_loop_fifo_proc: PROC_WIDTH_BYTES must be >= 1");
        end
    endgenerate

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [OCC_W-1:0]  r_occupancy;
    logic [CNT_WIDTH-1:0] r_beatCount;

    logic              w_push;
    logic              w_pop;
    logic              w_sReady;
    logic              w_mValid;
    logic [DATA_W-1:0] w_xformData;

    // The transform is fixed at elaboration and is applied on the write side.
    // The read path is then a plain memory read, and the outbound data holds
    // trivially while the head entry waits for m_axis_tready.
    generate
        if (MODE == 1) begin : g_invert
            assign w_xformData = ~s_axis_tdata;
        end else if (MODE == 2) begin : g_byteRev
            for (genvar k = 0; k < PROC_WIDTH_BYTES; k++) begin : g_byte
                assign w_xformData[8*k +: 8] =
                    s_axis_tdata[8*(PROC_WIDTH_BYTES-1-k) +: 8];
            end
        end else begin : g_pass
            assign w_xformData = s_axis_tdata;
        end
    endgenerate

    // Handshake qualifiers. Both readies and valids are forced low while reset
    // is asserted. This prevents a beat from being accepted or offered from a
    // FIFO that is about to be flushed.
    always_comb begin
        w_sReady = arstn && (r_occupancy != OCC_FULL);
        w_mValid = arstn && (r_occupancy != OCC_EMPTY);
        w_push   = s_axis_tvalid && w_sReady;
        w_pop    = w_mValid && m_axis_tready;
    end

    // Storage array. It has no reset because contents beyond the occupancy
    // window are never observed. Only the slot at the write pointer changes.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_xformData;
        end
    end

    // Pointer, occupancy and counter state. A push and a pop in the same cycle
    // advance both pointers and leave the occupancy unchanged. An empty FIFO
    // never bypasses, so a new beat always appears one cycle after its push.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_occupancy <= '0;
            r_beatCount <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr     <= r_rdPtr + PTR_W'(1);
                r_beatCount <= r_beatCount + CNT_WIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occupancy <= r_occupancy + OCC_W'(1);
                2'b01:   r_occupancy <= r_occupancy - OCC_W'(1);
                default: r_occupancy <= r_occupancy;
            endcase
        end
    end

    assign s_axis_tready = w_sReady;
    assign m_axis_tvalid = w_mValid;
    assign m_axis_tdata  = r_mem[r_rdPtr];
    assign occupancy     = r_occupancy;
    assign beat_count    = r_beatCount;

endmodule

// File: tb/tb_axis_loop_fifo_proc.sv
// ---------------------------------------------------------------------------
// tb_axis_loop_fifo_proc
//
// Directed bench for axis_loop_fifo_proc with three instances:
//   u0 : MODE 0, 1 byte, DEPTH 4, 4-bit beat counter (main FIFO behaviour)
//   u1 : MODE 1, 1 byte (invert)
//   u2 : MODE 2, 4 bytes (byte reverse)
// The bench keeps a reference queue and occupancy for u0. Every u0 cycle is
// compared against that reference, and hand-computed checks are added at key
// points.
// ---------------------------------------------------------------------------
module tb_axis_loop_fifo_proc;

    logic clk = 1'b0;
    logic rstN;

    logic [7:0]  sData0;
    logic        sValid0;
    logic        sReady0;
    logic [7:0]  mData0;
    logic        mValid0;
    logic        mReady0;
    logic [2:0]  occ0;
    logic [3:0]  beat0;

    logic [7:0]  sData1;
    logic        sValid1;
    logic        sReady1;
    logic [7:0]  mData1;
    logic        mValid1;
    logic        mReady1;
    logic [2:0]  occ1;
    logic [31:0] beat1;

    logic [31:0] sData2;
    logic        sValid2;
    logic        sReady2;
    logic [31:0] mData2;
    logic        mValid2;
    logic        mReady2;
    logic [2:0]  occ2;
    logic [31:0] beat2;

    int numVectors = 0;
    int numMiscompares = 0;

    // Reference model state for u0
    logic [7:0] refQ[$];
    int         refOcc;
    logic [3:0] refBeat;

    always #5 clk = ~clk;

    axis_loop_fifo_proc #(.PROC_WIDTH_BYTES(1), .DEPTH(4), .MODE(0), .CNT_WIDTH(4)) u0 (
        .clk(clk), .arstn(rstN),
        .s_axis_tdata(sData0), .s_axis_tvalid(sValid0), .s_axis_tready(sReady0),
        .m_axis_tdata(mData0), .m_axis_tvalid(mValid0), .m_axis_tready(mReady0),
        .occupancy(occ0), .beat_count(beat0)
    );

    axis_loop_fifo_proc #(.PROC_WIDTH_BYTES(1), .DEPTH(4), .MODE(1), .CNT_WIDTH(32)) u1 (
        .clk(clk), .arstn(rstN),
        .s_axis_tdata(sData1), .s_axis_tvalid(sValid1), .s_axis_tready(sReady1),
        .m_axis_tdata(mData1), .m_axis_tvalid(mValid1), .m_axis_tready(mReady1),
        .occupancy(occ1), .beat_count(beat1)
    );

    axis_loop_fifo_proc #(.PROC_WIDTH_BYTES(4), .DEPTH(4), .MODE(2), .CNT_WIDTH(32)) u2 (
        .clk(clk), .arstn(rstN),
        .s_axis_tdata(sData2), .s_axis_tvalid(sValid2), .s_axis_tready(sReady2),
        .m_axis_tdata(mData2), .m_axis_tvalid(mValid2), .m_axis_tready(mReady2),
        .occupancy(occ2), .beat_count(beat2)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numVectors++;
        if (observed !== expected) begin
            numMiscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of u0 stimulus and compares u0 against the reference
    // before the edge. It then advances the clock and updates the reference
    // from the bench's own view of push/pop.
    task automatic applyStimulus(input logic rn, input logic sv, input logic [7:0] sd,
                                 input logic mr);
        bit expPush;
        bit expPop;
        rstN    = rn;
        sValid0 = sv;
        sData0  = sd;
        mReady0 = mr;
        #1;
        checkOutput("sReady", {31'd0, sReady0}, {31'd0, (rn && refOcc != 4)});
        checkOutput("mValid", {31'd0, mValid0}, {31'd0, (rn && refOcc != 0)});
        checkOutput("occupancy", {29'd0, occ0}, refOcc);
        checkOutput("beatCount", {28'd0, beat0}, {28'd0, refBeat});
        if (rn && refOcc != 0) begin
            checkOutput("mData", {24'd0, mData0}, {24'd0, refQ[0]});
        end
        expPush = rn && sv && (refOcc != 4);
        expPop  = rn && mr && (refOcc != 0);
        @(posedge clk);
        #1;
        if (!rn) begin
            refQ.delete();
            refOcc  = 0;
            refBeat = '0;
        end else begin
            if (expPop) begin
                void'(refQ.pop_front());
                refBeat = refBeat + 4'd1;
                refOcc--;
            end
            if (expPush) begin
                refQ.push_back(sd);
                refOcc++;
            end
        end
    endtask

    task automatic resetAll();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        rstN = 1'b0;
        sValid0 = 1'b0; sData0 = '0; mReady0 = 1'b0;
        sValid1 = 1'b0; sData1 = '0; mReady1 = 1'b0;
        sValid2 = 1'b0; sData2 = '0; mReady2 = 1'b0;
        refOcc  = 0;
        refBeat = '0;

        // Power-up reset: state is unknown before the first edge, so no checks
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstSReady", {31'd0, sReady0}, 32'd0);
        checkOutput("rstMValid", {31'd0, mValid0}, 32'd0);
        rstN = 1'b1;
        #1;
        checkOutput("postRstSReady", {31'd0, sReady0}, 32'd1);
        checkOutput("postRstMValid", {31'd0, mValid0}, 32'd0);
        checkOutput("postRstOcc", {29'd0, occ0}, 32'd0);
        checkOutput("postRstBeat", {28'd0, beat0}, 32'd0);

        // In-order pass-through with one cycle of latency
        applyStimulus(1'b1, 1'b1, 8'h11, 1'b1);
        checkOutput("t1First", {24'd0, mData0}, 32'h11);
        applyStimulus(1'b1, 1'b1, 8'h22, 1'b1);
        checkOutput("t1Second", {24'd0, mData0}, 32'h22);
        applyStimulus(1'b1, 1'b1, 8'h33, 1'b1);
        checkOutput("t1Third", {24'd0, mData0}, 32'h33);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        checkOutput("t1Beats", {28'd0, beat0}, 32'd3);
        checkOutput("t1Empty", {31'd0, mValid0}, 32'd0);

        // Fill under back-pressure: 6 offered, 4 accepted
        resetAll();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 8'hA0 + 8'(i), 1'b0);
            if (i == 3) begin
                checkOutput("t2ReadyAfter4th", {31'd0, sReady0}, 32'd0);
            end
        end
        checkOutput("t2Occ", {29'd0, occ0}, 32'd4);
        checkOutput("t2HeadHeld", {24'd0, mData0}, 32'hA0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        checkOutput("t2ReadyFreed", {31'd0, sReady0}, 32'd1);
        checkOutput("t2OccFreed", {29'd0, occ0}, 32'd3);

        // Refill to full, then stream with both sides held open
        applyStimulus(1'b1, 1'b1, 8'hA4, 1'b0);
        checkOutput("t3Full", {29'd0, occ0}, 32'd4);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 8'hC0 + 8'(i), 1'b1);
        end
        checkOutput("t3OccSteady", {29'd0, occ0}, 32'd3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        end

        // Transforms on the other two instances
        sValid1 = 1'b1; sData1 = 8'hA5;
        sValid2 = 1'b1; sData2 = 32'h01020304;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        sValid1 = 1'b0;
        sValid2 = 1'b0;
        #1;
        checkOutput("t4InvValid", {31'd0, mValid1}, 32'd1);
        checkOutput("t4InvData", {24'd0, mData1}, 32'h5A);
        checkOutput("t4RevValid", {31'd0, mValid2}, 32'd1);
        checkOutput("t4RevData", mData2, 32'h04030201);

        // Reset mid-stream flushes the buffered beats
        resetAll();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 8'h50 + 8'(i), 1'b0);
        end
        checkOutput("t5Loaded", {29'd0, occ0}, 32'd3);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        resetAll();
        checkOutput("t5Occ", {29'd0, occ0}, 32'd0);
        checkOutput("t5Valid", {31'd0, mValid0}, 32'd0);
        checkOutput("t5Beat", {28'd0, beat0}, 32'd0);
        applyStimulus(1'b1, 1'b1, 8'h77, 1'b0);
        checkOutput("t5FirstValid", {31'd0, mValid0}, 32'd1);
        checkOutput("t5FirstData", {24'd0, mData0}, 32'h77);

        // 17 beats through a 4-bit counter wraps it to 1
        resetAll();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(i * 3), 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        checkOutput("t6Wrap", {28'd0, beat0}, 32'd1);

        // Random stalls on both sides, then drain; the reference queue catches
        // loss, duplication or data changing while stalled
        for (int run = 0; run < 8; run++) begin
            resetAll();
            for (int c = 0; c < 30; c++) begin
                applyStimulus(1'b1, 1'($urandom_range(0, 1)), 8'($urandom),
                              1'($urandom_range(0, 1)));
            end
            for (int c = 0; c < 6; c++) begin
                applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
            end
            checkOutput("t6Drained", {29'd0, occ0}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule
